// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, serializer states and the data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } arb_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START_BIT,
    TX_DATA_BITS,
    TX_STOP_BIT
  } uart_tx_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping,
// returned one-hot together with a found flag.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);

  logic [N-1:0] rot_req;
  logic [N-1:0] rot_win;
  logic [N:0]   seen;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
  assign rot_req = N'({req, req} >> ptr);
  assign seen[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_prio
    assign rot_win[gi]  = rot_req[gi] & ~seen[gi];
    assign seen[gi + 1] = seen[gi] | rot_req[gi];
  end

  assign winner = N'(({rot_win, rot_win} << ptr) >> N);
  assign found  = seen[N];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic                           timeout_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LIMIT = CW'(LOCK_TIMEOUT);

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;

  logic [NUM_REQ-1:0]     pick_onehot;
  logic                   pick_found;
  logic [NUM_REQ-1:0]     grant_rot;
  logic [PW-1:0]          ptr_acc [NUM_REQ+1];
  logic [UART_DATA_W-1:0] lane_or [NUM_REQ+1];
  logic                   owner_valid;
  logic                   owner_last;

  uart_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .winner (pick_onehot),
    .found  (pick_found)
  );

  // The pointer after a release is the owner's index plus one; rotating the
  // one-hot grant first makes the wrap from NUM_REQ-1 to 0 free.
  assign grant_rot  = {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]};
  assign ptr_acc[0] = '0;
  assign lane_or[0] = '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign ptr_acc[gi + 1] = ptr_acc[gi] | (grant_rot[gi] ? PW'(gi) : '0);
    assign lane_or[gi + 1] = lane_or[gi] |
                             (grant_q[gi] ? req_data[gi*UART_DATA_W +: UART_DATA_W] : '0);
  end

  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    cnt_d     = '0;
    tmo_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // Waiting for busy low also covers a reset that landed mid-frame.
        if (!tx_busy && pick_found) begin
          grant_d = pick_onehot;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (owner_valid) begin
          tx_data_d = lane_or[NUM_REQ];
          last_d    = owner_last;
          state_d   = START;
        end else if (LOCK_TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TMO_LIMIT) begin
            tmo_d   = 1'b1;
            grant_d = '0;
            ptr_d   = ptr_acc[NUM_REQ];
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      START:   state_d = WAIT_HI;
      WAIT_HI: if (tx_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = ptr_acc[NUM_REQ];
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign tx_start    = (state_q == START);
  assign tx_data     = tx_data_q;
  assign timeout_err = tmo_q;
  assign req_ready   = (state_q == LOAD) ? (req_valid & grant_q) : '0;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte-stream requesters using packet-locked round-robin arbitration.
- Each requester presents bytes over a valid/ready handshake with a last marker.
- Once granted, a requester keeps the serializer until its last byte has finished transmitting, so its messages are never interleaved with others.
- Sits between the UART message sources and uart_tx, and drives uart_tx's start strobe and data word.

Parameters:
- NUM_REQ, 4: number of requesters; legal values 2..16.
- LOCK_TIMEOUT, 1024: cycles a locked requester may hold req_valid low mid-packet before the lock is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of its packet
- req_ready  out  NUM_REQ  byte accepted (one-hot, combinational)
- grant  out  NUM_REQ  one-hot lock owner; all zero when unlocked
- tx_start  out  1  start strobe to uart_tx, one cycle wide
- tx_data  out  8  byte to uart_tx, registered, stable while tx_start is high
- tx_busy  in  1  busy flag from uart_tx
- timeout_err  out  1  one-cycle pulse when a lock is dropped by timeout

Behaviour:
- Reset values: state IDLE; tx_start=0, tx_data=0, grant=0, timeout_err=0, req_ready=0; round-robin pointer set so requester 0 has highest priority.
- Reset is asynchronous, so outputs go to reset values immediately, including mid-packet. uart_tx is not reset by this block and may still be sending a frame.

FSM (enum in package):
- IDLE:
  - Pick a requester only when tx_busy=0 and |req_valid=1. This rule covers reset landing during a frame.
  - Winner is the first asserted req_valid searching upward from (last winner+1) mod NUM_REQ.
  - Register grant=onehot(winner) and go to LOAD.
- LOAD:
  - req_ready[g] = req_valid[g] (combinational); all other ready bits are 0.
  - If req_valid[g]=1: latch tx_data<=req_data[g] and last_r<=req_last[g], clear the timeout counter, go to START.
  - Otherwise increment the timeout counter. When LOCK_TIMEOUT!=0 and the counter reaches LOCK_TIMEOUT: pulse timeout_err, clear grant, set last winner=g, go to IDLE.
- START: tx_start=1 for exactly one cycle, then go to WAIT_HI.
- WAIT_HI: uart_tx raises busy one cycle after sampling start. Stay until tx_busy=1, then go to WAIT_LO.
- WAIT_LO: stay while tx_busy=1. On tx_busy=0:
  - If last_r=1: clear grant, set last winner=g, go to IDLE.
  - Otherwise go to LOAD; the lock is held.

Latency:
- First byte: req_valid rising in IDLE at cycle 0 gives grant and LOAD at cycle 1 (req_ready high when valid), then tx_start at cycle 2.
- Subsequent bytes: tx_busy low seen at cycle k gives LOAD at cycle k+1 and tx_start at cycle k+2.

Boundary conditions:
- Only one byte is accepted per serializer frame.
- req_ready never asserts outside LOAD.
- While locked, other requesters' valid signals are ignored and they may hold valid indefinitely.
- req_last on a single-byte packet releases the lock after that byte.
- The round-robin pointer wraps from NUM_REQ-1 to 0.
- A requester that re-asserts valid immediately after its own packet loses to any other pending requester.
- Requester data must be stable while its req_valid is high; the same requirement applies under a lock.
- The timeout counter is wide enough for LOCK_TIMEOUT. It counts only consecutive LOAD cycles with valid low and does not saturate past release.

Decomposition:
- Package uart_pkg holds:
  - the arbiter state enum (IDLE, LOAD, START, WAIT_HI, WAIT_LO);
  - the existing uart_tx_state_t, moved here;
  - the constant UART_DATA_W=8.
- One combinational sub-module, uart_rr_pick, takes a request vector and a pointer and returns the one-hot winner plus a valid flag. It is reusable by any future RX/TX arbiter.

Test Plan:
- Single requester, packet of two bytes: req0 sends 0x41 then 0x42 (last). Required: tx_start at cycles 2 and k+2, tx_data 0x41 then 0x42; grant=0001 throughout; grant=0 after busy falls.
- Simultaneous requests at reset: req0–req3 all valid with single-byte packets. Required: serving order 0,1,2,3, then 0 again on re-request; exactly one tx_start per frame.
- Packet lock: req1 sends a 3-byte packet while req2 is valid throughout. Required: all three req1 bytes go out before any req2 byte; req_ready[2]=0 until req1's last completes.
- Timeout: LOCK_TIMEOUT=8; req3 sends one non-last byte, then drops valid. Required: after 8 LOAD cycles, timeout_err pulses once, grant clears, and a pending req0 is served next.
- Reset during frame: assert rst_n=0 in WAIT_LO with tx_busy=1, release while tx_busy is still 1, with req1 valid. Required: no tx_start and no req_ready until tx_busy=0; then req1 is granted.
- Handshake hygiene: tx_busy stuck 0 after start. Required: the FSM stays in WAIT_HI with no second tx_start. Check by assertion over 1000 cycles.
